// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I constants and fetch-stage types used by fetch, decode and immediate generation
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with flush, used for the instruction buffer and the address queue
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  // storage is not reset: contents are only observed through a non-zero count
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
  // pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32I fetch stage owning the PC, issuing imem reads and buffering {instr, pc} for decode
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [XLEN-1:0] pc_q, pc_d, aq_head;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, ib_cnt, aq_cnt;
  logic [CW:0] used;
  logic started_q, req_fire, rsp_keep, pop, ib_empty;
  fetch_entry_t ib_head, ib_in;
  assign ib_empty = ib_cnt == '0;
  assign pop = !ib_empty && if_ready && !redirect_valid;
  assign used = {1'b0, out_q} + {1'b0, ib_cnt} - (CW+1)'(pop);
  assign imem_req_valid = started_q && !redirect_valid && used < (CW+1)'(FIFO_DEPTH);
  assign imem_req_addr = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && drop_q == '0 && aq_cnt != '0 && !redirect_valid;
  assign ib_in = '{instr: imem_rsp_data, pc: aq_head};
  assign if_valid = !ib_empty;
  assign if_instr = ib_empty ? NOP : ib_head.instr;
  assign if_pc = ib_empty ? '0 : ib_head.pc;
  // next PC, in-flight count and count of responses still to be discarded after a redirect
  always_comb begin
    pc_d = redirect_valid ? word_align(redirect_pc) : req_fire ? pc_q + 32'd4 : pc_q;
    out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d = redirect_valid ? out_q - CW'(imem_rsp_valid) :
             (imem_rsp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end
  // fetch state; started_q holds off the first request until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      started_q <= 1'b1;
      pc_q      <= pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk(clk), .rst_n(rst_n), .flush_i(redirect_valid),
    .push_i(req_fire), .data_i(pc_q), .pop_i(rsp_keep),
    .data_o(aq_head), .count_o(aq_cnt)
  );
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk(clk), .rst_n(rst_n), .flush_i(redirect_valid),
    .push_i(rsp_keep), .data_i(ib_in), .pop_i(pop),
    .data_o(ib_head), .count_o(ib_cnt)
  );
endmodule
